// File: rtl/input_transfer_scheduler_if.sv
// Handshake and bus bundle for input_transfer_scheduler: control, BRAM read port, output stream.
// slave = the scheduler itself, master = whatever drives it.
interface input_transfer_scheduler_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ROW_LANES  = 3,
  parameter int ADDR_WIDTH = 16,
  parameter int CH_WIDTH   = 8,
  parameter int COL_WIDTH  = 8,
  parameter int PASS_WIDTH = 8
);
  logic                            i_start;
  logic                            i_abort;
  logic [CH_WIDTH-1:0]             i_channels;
  logic [COL_WIDTH-1:0]            i_cols;
  logic [PASS_WIDTH-1:0]           i_passes;
  logic [ADDR_WIDTH-1:0]           i_base_addr;
  logic                            o_rd_en;
  logic [ADDR_WIDTH-1:0]           o_rd_addr;
  logic [ROW_LANES*DATA_WIDTH-1:0] i_rd_data;
  logic [ROW_LANES*DATA_WIDTH-1:0] o_data;
  logic                            o_valid;
  logic                            i_ready;
  logic                            o_busy;
  logic                            o_done;
  logic [PASS_WIDTH-1:0]           o_pass_index;

  modport slave (
    input  i_start, i_abort, i_channels, i_cols, i_passes, i_base_addr, i_rd_data, i_ready,
    output o_rd_en, o_rd_addr, o_data, o_valid, o_busy, o_done, o_pass_index
  );

  modport master (
    output i_start, i_abort, i_channels, i_cols, i_passes, i_base_addr, i_rd_data, i_ready,
    input  o_rd_en, o_rd_addr, o_data, o_valid, o_busy, o_done, o_pass_index
  );
endinterface

// File: rtl/input_transfer_scheduler.sv
// Streams channels*cols BRAM words per pass, P passes, into a credit-gated skid buffer; BRAM_LATENCY+1 cycles
// from issue decision to buffered beat. Downstream stalls throttle reads via credit, so the buffer never overflows.
module input_transfer_scheduler #(
  parameter int DATA_WIDTH   = 32,
  parameter int ROW_LANES    = 3,
  parameter int ADDR_WIDTH   = 16,
  parameter int CH_WIDTH     = 8,
  parameter int COL_WIDTH    = 8,
  parameter int PASS_WIDTH   = 8,
  parameter int BRAM_LATENCY = 2,
  parameter int BUF_DEPTH    = 8
) (
  input logic                    i_clock,
  input logic                    i_reset,
  input_transfer_scheduler_if.slave bus
);

  localparam int LW = ROW_LANES * DATA_WIDTH;
  localparam int NW = CH_WIDTH + COL_WIDTH;
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 2;
  localparam int SW = ADDR_WIDTH + NW;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                  state_q;
  logic [NW-1:0]           n_last_q, offset_q;
  logic [PASS_WIDTH-1:0]   p_last_q, pass_q, pidx_q;
  logic [ADDR_WIDTH-1:0]   base_q, rd_addr_q;
  logic                    rd_en_q, done_q;
  logic [BRAM_LATENCY-1:0] sr_q;
  logic [LW-1:0]           mem_q [BUF_DEPTH];
  logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]           count_q;

  logic                    push, pop, credit_ok;
  logic [CW-1:0]           inflight, committed;
  logic [NW-1:0]           n_frame;
  logic [SW-1:0]           addr_sum;
  logic [BRAM_LATENCY:0]   sr_shift;

  // The read presented this cycle counts as in flight, so credit is never double-spent.
  always_comb begin
    inflight = CW'(rd_en_q);
    for (int i = 0; i < BRAM_LATENCY; i++) begin
      inflight = inflight + CW'(sr_q[i]);
    end
    committed = count_q + inflight;
  end

  assign credit_ok = committed < CW'(BUF_DEPTH);
  assign push      = sr_q[BRAM_LATENCY-1];
  assign pop       = (count_q != '0) && bus.i_ready;
  assign n_frame   = {{COL_WIDTH{1'b0}}, bus.i_channels} * {{CH_WIDTH{1'b0}}, bus.i_cols};
  assign addr_sum  = {{NW{1'b0}}, base_q} + {{ADDR_WIDTH{1'b0}}, offset_q};
  assign sr_shift  = {sr_q, rd_en_q};

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= IDLE;
      n_last_q  <= '0;
      offset_q  <= '0;
      p_last_q  <= '0;
      pass_q    <= '0;
      pidx_q    <= '0;
      base_q    <= '0;
      rd_addr_q <= '0;
      rd_en_q   <= 1'b0;
      done_q    <= 1'b0;
    end else if (bus.i_abort) begin
      state_q <= IDLE;
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.i_start) begin
            base_q   <= bus.i_base_addr;
            n_last_q <= n_frame - NW'(1);
            p_last_q <= (bus.i_passes == '0) ? '0 : bus.i_passes - PASS_WIDTH'(1);
            offset_q <= '0;
            pass_q   <= '0;
            pidx_q   <= '0;
            state_q  <= ((bus.i_channels == '0) || (bus.i_cols == '0)) ? DONE : ISSUE;
          end
        end
        ISSUE: begin
          if (credit_ok) begin
            rd_en_q   <= 1'b1;
            rd_addr_q <= addr_sum[ADDR_WIDTH-1:0];
            pidx_q    <= pass_q;
            if (offset_q == n_last_q) begin
              offset_q <= '0;
              if (pass_q == p_last_q) state_q <= DRAIN;
              else                    pass_q  <= pass_q + PASS_WIDTH'(1);
            end else begin
              offset_q <= offset_q + NW'(1);
            end
          end
        end
        DRAIN: begin
          if ((inflight == '0) && (count_q == '0)) state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      sr_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (bus.i_abort) begin
      sr_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      sr_q <= sr_shift[BRAM_LATENCY-1:0];
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: o_data is masked to zero whenever the buffer is empty.
  always_ff @(posedge i_clock) begin
    if (push) mem_q[wr_ptr_q] <= bus.i_rd_data;
  end

  assign bus.o_rd_en      = rd_en_q;
  assign bus.o_rd_addr    = rd_addr_q;
  assign bus.o_valid      = (count_q != '0);
  assign bus.o_data       = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign bus.o_busy       = (state_q == ISSUE) || (state_q == DRAIN);
  assign bus.o_done       = done_q;
  assign bus.o_pass_index = pidx_q;

endmodule

// File: tb/tb_input_transfer_scheduler.sv
// Bench for input_transfer_scheduler: BRAM latency model plus an address/pass/data scoreboard.
module tb_input_transfer_scheduler;
  localparam int DW = 32, RL = 3, AW = 16, CHW = 8, COLW = 8, PSW = 8, LAT = 2, DEPTH = 8;
  localparam int LW = RL * DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  input_transfer_scheduler_if #(.DATA_WIDTH(DW), .ROW_LANES(RL), .ADDR_WIDTH(AW),
    .CH_WIDTH(CHW), .COL_WIDTH(COLW), .PASS_WIDTH(PSW)) bus();

  input_transfer_scheduler #(.DATA_WIDTH(DW), .ROW_LANES(RL), .ADDR_WIDTH(AW), .CH_WIDTH(CHW),
    .COL_WIDTH(COLW), .PASS_WIDTH(PSW), .BRAM_LATENCY(LAT), .BUF_DEPTH(DEPTH)) dut (
    .i_clock(clk), .i_reset(rst_n), .bus(bus));

  function automatic logic [LW-1:0] mkdata(input logic [AW-1:0] a);
    logic [LW-1:0] d;
    d = '0;
    for (int k = 0; k < RL; k++) d[k*DW +: DW] = {a, 8'(k + 1), 8'hC3};
    return d;
  endfunction

  // BRAM model: data for an address appears LAT cycles after the read is presented.
  logic [LAT-1:0] pv = '0;
  logic [AW-1:0]  pa [LAT];
  always @(posedge clk) begin
    pv    <= {pv[LAT-2:0], bus.o_rd_en};
    pa[0] <= bus.o_rd_addr;
    for (int i = 1; i < LAT; i++) pa[i] <= pa[i-1];
  end
  assign bus.i_rd_data = pv[LAT-1] ? mkdata(pa[LAT-1]) : {(LW/16){16'hDEAD}};

  logic [AW-1:0] addr_q[$];
  int            pidx_q[$];
  logic [LW-1:0] data_q[$];
  int total = 0;
  int bad = 0;

  task automatic clear_sb();
    addr_q.delete();
    pidx_q.delete();
    data_q.delete();
  endtask

  // Called on a falling edge; pushes the expected reads/beats, pulses start for one cycle.
  task automatic launch(input int ch, input int cols, input int passes, input logic [AW-1:0] base);
    int n, p;
    logic [AW-1:0] a;
    n = ch * cols;
    p = (passes == 0) ? 1 : passes;
    if (n > 0) begin
      for (int pp = 0; pp < p; pp++) begin
        for (int o = 0; o < n; o++) begin
          a = base + AW'(o);
          addr_q.push_back(a);
          pidx_q.push_back(pp);
          data_q.push_back(mkdata(a));
        end
      end
    end
    bus.i_channels  = CHW'(ch);
    bus.i_cols      = COLW'(cols);
    bus.i_passes    = PSW'(passes);
    bus.i_base_addr = base;
    bus.i_start     = 1'b1;
    @(negedge clk);
    bus.i_start     = 1'b0;
    bus.i_channels  = CHW'($urandom);
    bus.i_cols      = COLW'($urandom);
    bus.i_passes    = PSW'($urandom);
    bus.i_base_addr = AW'($urandom);
  endtask

  // mode 0: ready=1, 1: random ready, 2: ready=0. Stops at o_done or after max_cyc cycles.
  task automatic watch(input int max_cyc, input int mode, output int reads, output int beats,
                       output int dones, output int first_b, output int last_b);
    logic [LW-1:0] hold_d, ed;
    logic [AW-1:0] ea;
    logic          hold_v;
    int            ep;
    reads = 0; beats = 0; dones = 0; first_b = -1; last_b = -1;
    hold_v = 1'b0; hold_d = '0;
    for (int c = 0; c < max_cyc && dones == 0; c++) begin
      @(negedge clk);
      if (hold_v) begin
        total++;
        if (bus.o_valid !== 1'b1 || bus.o_data !== hold_d) begin
          bad++;
          $display("FAIL hold_stable cyc=%0d valid=%0b data=%h want=%h", c, bus.o_valid, bus.o_data, hold_d);
        end
      end
      if (bus.o_rd_en === 1'b1) begin
        reads++;
        total++;
        if (addr_q.size() == 0) begin
          bad++;
          $display("FAIL extra_read addr=%h", bus.o_rd_addr);
        end else begin
          ea = addr_q.pop_front();
          ep = pidx_q.pop_front();
          if (bus.o_rd_addr !== ea || bus.o_pass_index !== PSW'(ep)) begin
            bad++;
            $display("FAIL rd_addr got=%h/pass%0d want=%h/pass%0d", bus.o_rd_addr, bus.o_pass_index, ea, ep);
          end
        end
      end
      case (mode)
        0:       bus.i_ready = 1'b1;
        1:       bus.i_ready = 1'($urandom_range(0, 1));
        default: bus.i_ready = 1'b0;
      endcase
      if (bus.o_valid === 1'b1 && bus.i_ready === 1'b1) begin
        beats++;
        if (first_b < 0) first_b = c;
        last_b = c;
        total++;
        if (data_q.size() == 0) begin
          bad++;
          $display("FAIL extra_beat data=%h", bus.o_data);
        end else begin
          ed = data_q.pop_front();
          if (bus.o_data !== ed) begin
            bad++;
            $display("FAIL beat_data got=%h want=%h", bus.o_data, ed);
          end
        end
      end
      hold_v = (bus.o_valid === 1'b1) && (bus.i_ready === 1'b0);
      hold_d = bus.o_data;
      if (bus.o_done === 1'b1) dones++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.o_rd_en, bus.o_valid, bus.o_busy, bus.o_done} !== 4'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=0000", {bus.o_rd_en, bus.o_valid, bus.o_busy, bus.o_done});
    end
    total++;
    if (bus.o_rd_addr !== '0 || bus.o_data !== '0 || bus.o_pass_index !== '0) begin
      bad++;
      $display("FAIL reset_bus addr=%h data=%h pass=%0d want 0", bus.o_rd_addr, bus.o_data, bus.o_pass_index);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (bus.o_busy !== 1'b0 || bus.o_rd_en !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_idle busy=%b rd_en=%b want 0", bus.o_busy, bus.o_rd_en);
    end
  endtask

  task automatic test_basic();
    int r, b, d, f, l;
    clear_sb();
    bus.i_ready = 1'b1;
    launch(2, 3, 2, 16'h0100);
    total++;
    if (bus.o_busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b want=1", bus.o_busy); end
    watch(200, 0, r, b, d, f, l);
    total++;
    if (r != 12 || b != 12 || d != 1) begin
      bad++;
      $display("FAIL basic_counts reads=%0d beats=%0d done=%0d want 12/12/1", r, b, d);
    end
    total++;
    if (l - f != 11) begin bad++; $display("FAIL basic_throughput span=%0d want 11", l - f); end
    @(negedge clk);
    total++;
    if (bus.o_done !== 1'b0 || bus.o_busy !== 1'b0 || addr_q.size() != 0 || data_q.size() != 0) begin
      bad++;
      $display("FAIL basic_end done=%b busy=%b left=%0d/%0d want 0", bus.o_done, bus.o_busy, addr_q.size(), data_q.size());
    end
  endtask

  task automatic test_backpressure();
    int r, b, d, f, l;
    clear_sb();
    bus.i_ready = 1'b0;
    launch(2, 3, 2, 16'h0100);
    watch(30, 2, r, b, d, f, l);
    total++;
    if (r != DEPTH || b != 0 || d != 0 || bus.o_valid !== 1'b1) begin
      bad++;
      $display("FAIL stall_reads reads=%0d beats=%0d valid=%b want %0d/0/1", r, b, bus.o_valid, DEPTH);
    end
    watch(200, 0, r, b, d, f, l);
    total++;
    if (r != 12 - DEPTH || b != 12 || d != 1 || data_q.size() != 0) begin
      bad++;
      $display("FAIL release_counts reads=%0d beats=%0d done=%0d want %0d/12/1", r, b, d, 12 - DEPTH);
    end
  endtask

  task automatic test_zero_frame();
    logic [2:0] dpat;
    logic       saw_rd;
    for (int t = 0; t < 2; t++) begin
      clear_sb();
      bus.i_ready = 1'b1;
      if (t == 0) launch(0, 3, 2, 16'h0010);
      else        launch(5, 0, 1, 16'h0020);
      dpat = '0;
      saw_rd = 1'b0;
      for (int c = 0; c < 3; c++) begin
        if (c > 0) @(negedge clk);
        dpat[c] = bus.o_done;
        if (bus.o_rd_en !== 1'b0 || bus.o_busy !== 1'b0) saw_rd = 1'b1;
      end
      total++;
      if (dpat !== 3'b010 || saw_rd) begin
        bad++;
        $display("FAIL zero_frame case=%0d done_pattern=%b rd_or_busy=%b want 010/0", t, dpat, saw_rd);
      end
    end
  endtask

  task automatic test_abort();
    int   seen, r, b, d, f, l;
    logic late;
    clear_sb();
    bus.i_ready = 1'b0;
    launch(1, 8, 1, 16'h0200);
    seen = 0;
    for (int c = 0; c < 10 && seen < 2; c++) begin
      @(negedge clk);
      if (bus.o_rd_en === 1'b1) seen++;
    end
    total++;
    if (seen != 2) begin bad++; $display("FAIL abort_setup reads=%0d want 2", seen); end
    bus.i_abort = 1'b1;
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_abort = 1'b0;
    bus.i_start = 1'b0;
    total++;
    if (bus.o_busy !== 1'b0 || bus.o_valid !== 1'b0 || bus.o_rd_en !== 1'b0) begin
      bad++;
      $display("FAIL abort_idle busy=%b valid=%b rd_en=%b want 000", bus.o_busy, bus.o_valid, bus.o_rd_en);
    end
    late = 1'b0;
    bus.i_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (bus.o_valid !== 1'b0 || bus.o_done !== 1'b0 || bus.o_busy !== 1'b0) late = 1'b1;
    end
    total++;
    if (late) begin bad++; $display("FAIL abort_late_push activity=%b want 0", late); end
    clear_sb();
    launch(1, 8, 1, 16'h0200);
    watch(200, 0, r, b, d, f, l);
    total++;
    if (r != 8 || b != 8 || d != 1) begin
      bad++;
      $display("FAIL abort_restart reads=%0d beats=%0d done=%0d want 8/8/1", r, b, d);
    end
  endtask

  task automatic test_wrap();
    int r, b, d, f, l;
    clear_sb();
    launch(2, 2, 1, 16'hFFFE);
    watch(200, 1, r, b, d, f, l);
    total++;
    if (r != 4 || b != 4 || d != 1) begin
      bad++;
      $display("FAIL wrap_counts reads=%0d beats=%0d done=%0d want 4/4/1", r, b, d);
    end
  endtask

  task automatic test_reset_mid();
    int r, b, d, f, l;
    clear_sb();
    launch(4, 4, 3, 16'h0300);
    watch(20, 1, r, b, d, f, l);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.o_rd_en, bus.o_valid, bus.o_busy, bus.o_done} !== 4'b0 || bus.o_rd_addr !== '0 ||
        bus.o_data !== '0 || bus.o_pass_index !== '0) begin
      bad++;
      $display("FAIL mid_reset ctrl=%b addr=%h pass=%0d want all 0",
               {bus.o_rd_en, bus.o_valid, bus.o_busy, bus.o_done}, bus.o_rd_addr, bus.o_pass_index);
    end
    clear_sb();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (bus.o_busy !== 1'b0 || bus.o_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_release busy=%b valid=%b want 00", bus.o_busy, bus.o_valid);
    end
    launch(2, 3, 1, 16'h0040);
    watch(300, 1, r, b, d, f, l);
    total++;
    if (r != 6 || b != 6 || d != 1 || data_q.size() != 0) begin
      bad++;
      $display("FAIL mid_reset_frame reads=%0d beats=%0d done=%0d want 6/6/1", r, b, d);
    end
  endtask

  initial begin
    bus.i_start = 1'b0; bus.i_abort = 1'b0; bus.i_ready = 1'b1;
    bus.i_channels = '0; bus.i_cols = '0; bus.i_passes = '0; bus.i_base_addr = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_frame();
    test_abort();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/input_transfer_scheduler.md
INPUT_TRANSFER_SCHEDULER -- requirements
Module: input_transfer_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of one lane word.
REQ-002 SHALL have parameter ROW_LANES, default 3, number of kernel rows delivered in parallel per beat.
REQ-003 SHALL have parameter ADDR_WIDTH, default 16, BRAM address width.
REQ-004 SHALL have parameters CH_WIDTH, COL_WIDTH, PASS_WIDTH, each default 8, widths of the channel, column and pass count inputs.
REQ-005 SHALL have parameter BRAM_LATENCY, default 2, range 1-4, cycles from o_rd_en to valid i_rd_data.
REQ-006 SHALL have parameter BUF_DEPTH, default 8, power of two, >= BRAM_LATENCY+1, the output skid buffer depth.
REQ-007 SHALL have ports i_clock (in, 1, clock) and i_reset (in, 1, reset); one clock, reset asynchronous and active-low.
REQ-008 SHALL have i_start (in, 1, launch pulse) and i_abort (in, 1, cancel pulse).
REQ-009 SHALL have i_channels (in, CH_WIDTH), i_cols (in, COL_WIDTH), i_passes (in, PASS_WIDTH) and i_base_addr (in, ADDR_WIDTH): frame geometry, repeat count and start address.
REQ-010 SHALL have o_rd_en (out, 1), o_rd_addr (out, ADDR_WIDTH) and i_rd_data (in, ROW_LANES*DATA_WIDTH): BRAM read port.
REQ-011 SHALL have o_data (out, ROW_LANES*DATA_WIDTH), o_valid (out, 1) and i_ready (in, 1): downstream stream.
REQ-012 SHALL have o_busy (out, 1), o_done (out, 1, one-cycle pulse) and o_pass_index (out, PASS_WIDTH, current pass).

Function
REQ-013 SHALL implement states IDLE, ISSUE, DRAIN and DONE.
REQ-014 IDLE: on i_start, SHALL latch all configuration inputs; if channels==0 or cols==0, go to DONE with no reads; otherwise go to ISSUE.
REQ-015 SHALL ignore i_start outside IDLE; configuration inputs SHALL be don't-care after latching.
REQ-016 Frame length N = channels*cols, computed at CH_WIDTH+COL_WIDTH bits; effective passes P = max(i_passes,1).
REQ-017 ISSUE: SHALL assert o_rd_en only when credit = BUF_DEPTH - occupancy - inflight > 0, with o_rd_addr = base + offset truncated modulo 2^ADDR_WIDTH.
REQ-018 Per issued read, offset SHALL increment; at offset N-1 it SHALL wrap to 0 and o_pass_index SHALL increment.
REQ-019 After the read at offset N-1 of pass P-1, SHALL go to DRAIN.
REQ-020 SHALL track in-flight reads in a BRAM_LATENCY-deep valid shift register; on each emerging valid, i_rd_data SHALL be pushed into the buffer in issue order.
REQ-021 Credit gating SHALL guarantee that a push never occurs when the buffer is full; push and pop in the same cycle SHALL be legal at any occupancy.
REQ-022 o_valid SHALL equal buffer non-empty; o_data SHALL be the head entry and SHALL hold stable while o_valid && !i_ready; a beat transfers on o_valid && i_ready.
REQ-023 DRAIN: when inflight==0 and the buffer is empty, SHALL go to DONE.
REQ-024 DONE: SHALL assert o_done for exactly one cycle, then return to IDLE.
REQ-025 o_busy SHALL be 1 in ISSUE and DRAIN, 0 in IDLE and DONE.
REQ-026 i_abort in any state SHALL return to IDLE next cycle, clear the buffer, clear the valid shift register (returning data dropped), and SHALL NOT pulse o_done; i_abort wins over a simultaneous i_start.
REQ-027 Sustained throughput with i_ready=1 SHALL be one beat per cycle once the pipeline fills.

Reset
REQ-028 On i_reset low, SHALL immediately force IDLE, and set o_rd_en=0, o_rd_addr=0, o_valid=0, o_data=0, o_busy=0, o_done=0, o_pass_index=0, buffer and shift register empty.
REQ-029 Reset mid-operation SHALL discard all in-flight and buffered data; the first cycle after release SHALL be IDLE.

Verification
REQ-030 channels=2, cols=3, passes=2, base=0x100, i_ready=1 -> 12 reads at 0x100..0x105 twice, 12 beats in order, o_pass_index 0 then 1, o_done one pulse.
REQ-031 Same config with i_ready=0 -> exactly BUF_DEPTH reads issued then o_rd_en stalls; releasing i_ready delivers all 12 beats with no loss or duplication.
REQ-032 channels=0 -> o_done pulses two cycles after i_start, o_rd_en never asserted.
REQ-033 i_abort while 2 reads in flight -> IDLE next cycle, o_valid=0, no late push, no o_done; a following i_start restarts at offset 0.
REQ-034 base=0xFFFE, N=4 -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-035 i_reset asserted mid-ISSUE with random i_ready -> all outputs 0 immediately; i_start after release runs a clean frame.
